// File: rtl/game_round_sequencer_pkg.sv
// Shared state encodings, default timing constants and sizing helper for the
// match-level round sequencer.
package game_round_sequencer_pkg;

  typedef enum logic [1:0] {
    GRS_PLAY       = 2'd0,
    GRS_TIMER      = 2'd1,
    GRS_TALLY      = 2'd2,
    GRS_MATCH_OVER = 2'd3
  } grs_state_e;

  localparam int DEF_PRESCALE         = 25_000_000;
  localparam int DEF_TIMER_UNITS      = 2;
  localparam int DEF_ROUNDS_PER_MATCH = 5;
  localparam int DEF_SCORE_W          = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    if ($clog2(max_val + 1) < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// Handshake between game_master_fsm (master) and the round sequencer (slave).
interface game_round_sequencer_if;

  logic end_of_game_timer_start;
  logic game_won;
  logic end_of_game_timer_running;

  modport master (
    output end_of_game_timer_start,
    output game_won,
    input  end_of_game_timer_running
  );

  modport slave (
    input  end_of_game_timer_start,
    input  game_won,
    output end_of_game_timer_running
  );

endinterface

// File: rtl/game_pause_timer.sv
// Prescaled countdown: load arms it for 'units' periods of PRESCALE cycles,
// tick marks every prescaler wrap and done marks the final one.
module game_pause_timer
  import game_round_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int UNITS_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [UNITS_W-1:0] units,
  output logic               running,
  output logic               tick,
  output logic               done
);

  localparam int               PRE_W   = width_for(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   pre_r;
  logic [UNITS_W-1:0] units_r;
  logic               active_r;

  assign running = active_r;
  assign tick    = active_r && (pre_r == PRE_MAX);
  assign done    = tick && (units_r == UNITS_W'(1));

  // Prescaler and remaining-unit counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_r    <= {PRE_W{1'b0}};
      units_r  <= {UNITS_W{1'b0}};
      active_r <= 1'b0;
    end else if (load) begin
      pre_r    <= {PRE_W{1'b0}};
      units_r  <= units;
      active_r <= (units != {UNITS_W{1'b0}});
    end else if (tick) begin
      pre_r    <= {PRE_W{1'b0}};
      units_r  <= units_r - UNITS_W'(1);
      active_r <= !done;
    end else if (active_r) begin
      pre_r    <= pre_r + PRE_W'(1);
    end else begin
      pre_r    <= pre_r;
    end
  end

endmodule

// File: rtl/game_round_sequencer.sv
// Match controller above game_master_fsm: runs the end-of-round pause, tallies
// hits/misses and holds the master in its end state once the match is over.
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int PRESCALE         = DEF_PRESCALE,
  parameter int TIMER_UNITS      = DEF_TIMER_UNITS,
  parameter int ROUNDS_PER_MATCH = DEF_ROUNDS_PER_MATCH,
  parameter int SCORE_W          = DEF_SCORE_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  key,
  game_round_sequencer_if.slave                 master_bus,
  output logic                                  flash,
  output logic [SCORE_W-1:0]                    score,
  output logic [SCORE_W-1:0]                    misses,
  output logic [$clog2(ROUNDS_PER_MATCH+1)-1:0] round_num,
  output logic                                  match_over
);

  localparam int ROUND_W = $clog2(ROUNDS_PER_MATCH + 1);
  localparam int UNITS_W = width_for(TIMER_UNITS);

  grs_state_e         state_r, state_s;
  logic               load_s, tick_s, done_s, timer_running_s, key_rise_s;
  logic               key_q_r, won_r, running_r, flash_r, match_over_r;
  logic [SCORE_W-1:0] score_r, misses_r;
  logic [ROUND_W-1:0] round_r, round_next_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) begin
      return v;
    end else begin
      return v + SCORE_W'(1);
    end
  endfunction

  game_pause_timer #(
    .PRESCALE (PRESCALE),
    .UNITS_W  (UNITS_W)
  ) u_pause_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .units   (UNITS_W'(TIMER_UNITS)),
    .running (timer_running_s),
    .tick    (tick_s),
    .done    (done_s)
  );

  assign key_rise_s   = key & ~key_q_r;
  assign round_next_s = round_r + ROUND_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= GRS_PLAY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a timer that stops without done falls back to PLAY
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      GRS_PLAY: begin
        if (master_bus.end_of_game_timer_start) begin
          state_s = GRS_TIMER;
          load_s  = 1'b1;
        end else begin
          state_s = GRS_PLAY;
        end
      end
      GRS_TIMER: begin
        if (done_s) begin
          state_s = GRS_TALLY;
        end else if (!timer_running_s) begin
          state_s = GRS_PLAY;
        end else begin
          state_s = GRS_TIMER;
        end
      end
      GRS_TALLY: begin
        if (round_next_s == ROUND_W'(ROUNDS_PER_MATCH)) begin
          state_s = GRS_MATCH_OVER;
        end else begin
          state_s = GRS_PLAY;
        end
      end
      GRS_MATCH_OVER: begin
        if (key_rise_s) begin
          state_s = GRS_PLAY;
        end else begin
          state_s = GRS_MATCH_OVER;
        end
      end
      default: begin
        state_s = GRS_PLAY;
      end
    endcase
  end

  // Registered outputs, won latch, key edge register and match counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q_r      <= 1'b0;
      won_r        <= 1'b0;
      running_r    <= 1'b0;
      flash_r      <= 1'b0;
      match_over_r <= 1'b0;
      score_r      <= {SCORE_W{1'b0}};
      misses_r     <= {SCORE_W{1'b0}};
      round_r      <= {ROUND_W{1'b0}};
    end else begin
      key_q_r      <= key;
      running_r    <= (state_s == GRS_TIMER) || (state_s == GRS_MATCH_OVER);
      match_over_r <= (state_s == GRS_MATCH_OVER);
      if (state_s != GRS_TIMER) begin
        flash_r <= 1'b0;
      end else if (tick_s) begin
        flash_r <= ~flash_r;
      end else begin
        flash_r <= flash_r;
      end
      if (state_r == GRS_TIMER) begin
        won_r <= won_r | master_bus.game_won;
      end else if (state_r == GRS_TALLY) begin
        won_r <= 1'b0;
      end else begin
        won_r <= won_r;
      end
      if (state_r == GRS_TALLY) begin
        score_r  <= won_r ? sat_inc(score_r) : score_r;
        misses_r <= won_r ? misses_r : sat_inc(misses_r);
        round_r  <= round_next_s;
      end else if ((state_r == GRS_MATCH_OVER) && key_rise_s) begin
        score_r  <= {SCORE_W{1'b0}};
        misses_r <= {SCORE_W{1'b0}};
        round_r  <= {ROUND_W{1'b0}};
      end else begin
        round_r  <= round_r;
      end
    end
  end

  assign master_bus.end_of_game_timer_running = running_r;
  assign flash      = flash_r;
  assign score      = score_r;
  assign misses     = misses_r;
  assign round_num  = round_r;
  assign match_over = match_over_r;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Drives two sequencers (2-bit and 1-bit scores) with shared directed and
// random stimulus and compares them against a cycle-count reference model.
module tb_game_round_sequencer;

  localparam int P   = 4;
  localparam int U   = 3;
  localparam int RND = 3;

  logic clk = 1'b0;
  logic reset, key, start, won;
  always #5 clk = ~clk;

  game_round_sequencer_if if_a ();
  game_round_sequencer_if if_b ();
  assign if_a.end_of_game_timer_start = start;
  assign if_a.game_won                = won;
  assign if_b.end_of_game_timer_start = start;
  assign if_b.game_won                = won;

  logic       run_a, flash_a, over_a, run_b, flash_b, over_b;
  logic [1:0] score_a, misses_a, round_a, round_b;
  logic [0:0] score_b, misses_b;
  assign run_a = if_a.end_of_game_timer_running;
  assign run_b = if_b.end_of_game_timer_running;

  game_round_sequencer #(.PRESCALE(P), .TIMER_UNITS(U), .ROUNDS_PER_MATCH(RND), .SCORE_W(2)) dut_a (
    .clk(clk), .reset(reset), .key(key), .master_bus(if_a), .flash(flash_a),
    .score(score_a), .misses(misses_a), .round_num(round_a), .match_over(over_a));

  game_round_sequencer #(.PRESCALE(P), .TIMER_UNITS(U), .ROUNDS_PER_MATCH(RND), .SCORE_W(1)) dut_b (
    .clk(clk), .reset(reset), .key(key), .master_bus(if_b), .flash(flash_b),
    .score(score_b), .misses(misses_b), .round_num(round_b), .match_over(over_b));

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Reference model: elapsed pause cycles (-1 = no pause), pending tally, match over
  int m_elapsed, m_tally, m_over, m_won, m_keyq, m_round;
  int m_score[2];
  int m_misses[2];
  int smax[2] = '{3, 1};

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic w, input logic k);
    if (!r) begin
      m_elapsed = -1; m_tally = 0; m_over = 0; m_won = 0; m_keyq = 0; m_round = 0;
      for (int i = 0; i < 2; i++) begin m_score[i] = 0; m_misses[i] = 0; end
    end else begin
      if (m_tally != 0) begin
        for (int i = 0; i < 2; i++) begin
          if (m_won != 0) m_score[i] = (m_score[i] < smax[i]) ? m_score[i] + 1 : m_score[i];
          else            m_misses[i] = (m_misses[i] < smax[i]) ? m_misses[i] + 1 : m_misses[i];
        end
        m_round++;
        m_won = 0;
        m_tally = 0;
        if (m_round == RND) m_over = 1;
      end else if (m_over != 0) begin
        if (k && (m_keyq == 0)) begin
          m_over = 0; m_round = 0;
          for (int i = 0; i < 2; i++) begin m_score[i] = 0; m_misses[i] = 0; end
        end
      end else if (m_elapsed >= 0) begin
        if (w) m_won = 1;
        m_elapsed++;
        if (m_elapsed == P * U) begin
          m_elapsed = -1;
          m_tally = 1;
        end
      end else if (s) begin
        m_elapsed = 0;
      end
      m_keyq = k ? 1 : 0;
    end
  endtask

  task automatic check_all();
    int exp_run, exp_flash;
    exp_run   = ((m_elapsed >= 0) || (m_over != 0)) ? 1 : 0;
    exp_flash = ((m_elapsed >= 0) && (((m_elapsed / P) % 2) == 1)) ? 1 : 0;
    check_val("running_a", run_a, exp_run);
    check_val("running_b", run_b, exp_run);
    check_val("flash_a", flash_a, exp_flash);
    check_val("flash_b", flash_b, exp_flash);
    check_val("over_a", over_a, m_over);
    check_val("over_b", over_b, m_over);
    check_val("round_a", round_a, m_round);
    check_val("round_b", round_b, m_round);
    check_val("score_a", score_a, m_score[0]);
    check_val("score_b", score_b, m_score[1]);
    check_val("misses_a", misses_a, m_misses[0]);
    check_val("misses_b", misses_b, m_misses[1]);
  endtask

  // One cycle: check current outputs at negedge, then apply this cycle's inputs
  task automatic step(input logic r, input logic s, input logic w, input logic k);
    @(negedge clk);
    cyc_n++;
    check_all();
    reset = r; start = s; won = w; key = k;
    model_step(r, s, w, k);
  endtask

  function automatic logic idle();
    return (m_elapsed < 0) && (m_tally == 0) && (m_over == 0);
  endfunction

  initial begin
    int guard, len;
    reset = 1'b0; start = 1'b0; won = 1'b0; key = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Round 1: start in cycle 10, stray start in 15, late hit in 20
    for (int k = 2; k <= 30; k++) begin
      step(1'b1, k == 10 || k == 15, k == 20, 1'b0);
      if (k == 11 || k == 22) check_val("pause_edge_run", run_a, 1);
      if (k == 10) check_val("pre_pause_run", run_a, 0);
      if (k == 15) check_val("flash_after14", flash_a, 1);
      if (k == 19) check_val("flash_after18", flash_a, 0);
      if (k == 23) begin
        check_val("tally_run", run_a, 0);
        check_val("tally_flash", flash_a, 0);
      end
      if (k == 24) begin
        check_val("r1_round", round_a, 1);
        check_val("r1_score", score_a, 1);
        check_val("r1_misses", misses_a, 0);
      end
    end

    // Rounds 2 (lost) and 3 (won), then starts during MATCH_OVER
    guard = 0;
    while ((m_over == 0) && (guard < 200)) begin
      step(1'b1, idle(), (m_round != 1) && (m_elapsed >= 0), 1'b0);
      guard++;
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("end_score", score_a, 2);
    check_val("end_misses", misses_a, 1);
    check_val("end_round", round_a, 3);
    check_val("end_over", over_a, 1);
    check_val("end_running", run_a, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("restart_score", score_a, 0);
    check_val("restart_round", round_a, 0);
    check_val("restart_over", over_a, 0);
    check_val("restart_running", run_a, 0);

    // Reset mid-pause, then a full-length pause
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_running", run_a, 0);
    check_val("rst_flash", flash_a, 0);
    check_val("rst_round", round_a, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (run_a) len++;
    end
    check_val("pause_len", len, P * U);
    check_val("rst_then_misses", misses_a, 1);

    // Back to a fresh match, then three wins with the key held throughout
    step(1'b0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while ((m_over == 0) && (guard < 200)) begin
      step(1'b1, idle(), m_elapsed >= 0, 1'b1);
      guard++;
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("held_over", over_a, 1);
    check_val("sat_score_b", score_b, 1);
    check_val("score_a_3", score_a, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("repress_over", over_a, 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, ($urandom_range(0, 9) == 0) ? ~key : key);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
